// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA tile generator:
//   - default timing sets for 800x600@72 and 640x480@60
//   - rgb_t: packed {r,g,b} pixel at the default channel width
//   - h_total / v_total: line and frame length helpers
//   - idx_w: counter width able to hold 0..n-1
// Optional feature macro used by the users of this package: VGA_BORDER_EN.
// -----------------------------------------------------------------------------
package vga_pkg;

   // 800x600@72 (50 MHz pixel clock)
   localparam int SVGA72_H_VISIBLE = 800;
   localparam int SVGA72_H_FP      = 56;
   localparam int SVGA72_H_SYNC    = 120;
   localparam int SVGA72_H_BP      = 64;
   localparam int SVGA72_V_VISIBLE = 600;
   localparam int SVGA72_V_FP      = 37;
   localparam int SVGA72_V_SYNC    = 6;
   localparam int SVGA72_V_BP      = 23;

   // 640x480@60 (25.175 MHz pixel clock)
   localparam int VGA60_H_VISIBLE  = 640;
   localparam int VGA60_H_FP       = 16;
   localparam int VGA60_H_SYNC     = 96;
   localparam int VGA60_H_BP       = 48;
   localparam int VGA60_V_VISIBLE  = 480;
   localparam int VGA60_V_FP       = 10;
   localparam int VGA60_V_SYNC     = 2;
   localparam int VGA60_V_BP       = 33;

   localparam int DEF_CW = 4;

   typedef struct packed {
      logic [DEF_CW-1:0] r;
      logic [DEF_CW-1:0] g;
      logic [DEF_CW-1:0] b;
   } rgb_t;

   function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

   function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

   // Width of a counter that runs 0..n-1 (at least one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Raster counters and everything derived directly from them. All outputs are
// combinational decodes of the current counter state; the top registers them.
// Ports:
//   clk, rst     pixel clock, synchronous active-high reset
//   visible      h_cnt < H_VISIBLE && v_cnt < V_VISIBLE
//   hsync_act    h_cnt inside the horizontal sync window (polarity-free)
//   vsync_act    v_cnt inside the vertical sync window (polarity-free)
//   frame_first  h_cnt == 0 && v_cnt == 0
//   frame_end    h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1
//   col, row     current tile column / row
//   tile_edge    (VGA_BORDER_EN only) pixel is on the first/last column or
//                line of its tile
// Tile indices come from a sub-pixel counter that rolls over every tile width
// (height), so no divider is needed.
// -----------------------------------------------------------------------------
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = SVGA72_H_VISIBLE,
   parameter int H_FP      = SVGA72_H_FP,
   parameter int H_SYNC    = SVGA72_H_SYNC,
   parameter int H_BP      = SVGA72_H_BP,
   parameter int V_VISIBLE = SVGA72_V_VISIBLE,
   parameter int V_FP      = SVGA72_V_FP,
   parameter int V_SYNC    = SVGA72_V_SYNC,
   parameter int V_BP      = SVGA72_V_BP,
   parameter int COLS      = 2,
   parameter int ROWS      = 1,
   localparam int CIW      = idx_w(COLS),
   localparam int RIW      = idx_w(ROWS)
) (
   input  logic           clk,
   input  logic           rst,
   output logic           visible,
   output logic           hsync_act,
   output logic           vsync_act,
   output logic           frame_first,
   output logic [CIW-1:0] col,
   output logic [RIW-1:0] row,
`ifdef VGA_BORDER_EN
   output logic           tile_edge,
`endif
   output logic           frame_end
);

   localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
   localparam int HW      = idx_w(H_TOTAL);
   localparam int VW      = idx_w(V_TOTAL);
   localparam int TILE_W  = H_VISIBLE / COLS;
   localparam int TILE_H  = V_VISIBLE / ROWS;
   localparam int TWW     = idx_w(TILE_W);
   localparam int THW     = idx_w(TILE_H);

   logic [HW-1:0]  h_cnt_q,   h_cnt_d;
   logic [VW-1:0]  v_cnt_q,   v_cnt_d;
   logic [TWW-1:0] col_sub_q, col_sub_d;
   logic [THW-1:0] row_sub_q, row_sub_d;
   logic [CIW-1:0] col_q,     col_d;
   logic [RIW-1:0] row_q,     row_d;
   logic           h_wrap, v_wrap;

   always_comb begin
      // NOTE: every value written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      h_wrap    = (int'(h_cnt_q) == H_TOTAL - 1);
      v_wrap    = (int'(v_cnt_q) == V_TOTAL - 1);
      h_cnt_d   = h_cnt_q + 1'b1;
      v_cnt_d   = v_cnt_q;
      col_sub_d = col_sub_q + 1'b1;
      col_d     = col_q;
      row_sub_d = row_sub_q;
      row_d     = row_q;

      // Column tracking restarts every line. The sub-pixel counter keeps
      // rolling through blanking; the column index saturates on the last tile.
      if (h_wrap) begin
         h_cnt_d   = '0;
         col_sub_d = '0;
         col_d     = '0;
      end else if (int'(col_sub_q) == TILE_W - 1) begin
         col_sub_d = '0;
         if (int'(col_q) != COLS - 1) col_d = col_q + 1'b1;
      end

      // Lines advance only on the horizontal wrap; same scheme for rows.
      if (h_wrap) begin
         if (v_wrap) begin
            v_cnt_d   = '0;
            row_sub_d = '0;
            row_d     = '0;
         end else begin
            v_cnt_d = v_cnt_q + 1'b1;
            if (int'(row_sub_q) == TILE_H - 1) begin
               row_sub_d = '0;
               if (int'(row_q) != ROWS - 1) row_d = row_q + 1'b1;
            end else begin
               row_sub_d = row_sub_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop updates from the same
      // pre-edge values regardless of statement order.
      if (rst) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         col_sub_q <= '0;
         row_sub_q <= '0;
         col_q     <= '0;
         row_q     <= '0;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         col_sub_q <= col_sub_d;
         row_sub_q <= row_sub_d;
         col_q     <= col_d;
         row_q     <= row_d;
      end
   end

   assign visible     = (int'(h_cnt_q) < H_VISIBLE) && (int'(v_cnt_q) < V_VISIBLE);
   assign hsync_act   = (int'(h_cnt_q) >= H_VISIBLE + H_FP) &&
                        (int'(h_cnt_q) <  H_VISIBLE + H_FP + H_SYNC);
   assign vsync_act   = (int'(v_cnt_q) >= V_VISIBLE + V_FP) &&
                        (int'(v_cnt_q) <  V_VISIBLE + V_FP + V_SYNC);
   assign frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign frame_end   = h_wrap && v_wrap;
   assign col         = col_q;
   assign row         = row_q;

`ifdef VGA_BORDER_EN
   assign tile_edge = (col_sub_q == '0) || (int'(col_sub_q) == TILE_W - 1) ||
                      (row_sub_q == '0) || (int'(row_sub_q) == TILE_H - 1);
`endif

endmodule

// File: rtl/vga_tile_gen.sv
// -----------------------------------------------------------------------------
// vga_tile_gen
// VGA timing plus a COLS x ROWS grid of solid-colour tiles with a
// double-buffered colour code. Every output is registered one cycle after the
// counter state, so sync, enable and colour stay mutually aligned.
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   code          tile colours, tile k (row-major) at [W-1-3*CW*k -: 3*CW], R,G,B
//   code_load     capture code into the shadow register
//   border_rgb    (VGA_BORDER_EN only) colour painted on tile edges
//   pending       shadow holds a code not yet shown
//   hsync, vsync  sync outputs at the configured polarity
//   de            visible pixel
//   frame_start   pulse with the first visible pixel of a frame
//   red/green/blue colour channels, zero outside the visible area
// Optional feature macro: VGA_BORDER_EN.
// H_VISIBLE must be a multiple of COLS and V_VISIBLE a multiple of ROWS.
// -----------------------------------------------------------------------------
module vga_tile_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE  = SVGA72_H_VISIBLE,
   parameter int H_FP       = SVGA72_H_FP,
   parameter int H_SYNC     = SVGA72_H_SYNC,
   parameter int H_BP       = SVGA72_H_BP,
   parameter int V_VISIBLE  = SVGA72_V_VISIBLE,
   parameter int V_FP       = SVGA72_V_FP,
   parameter int V_SYNC     = SVGA72_V_SYNC,
   parameter int V_BP       = SVGA72_V_BP,
   parameter int H_SYNC_POL = 1,
   parameter int V_SYNC_POL = 1,
   parameter int COLS       = 2,
   parameter int ROWS       = 1,
   parameter int CW         = DEF_CW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [COLS*ROWS*3*CW-1:0]  code,
   input  logic                       code_load,
`ifdef VGA_BORDER_EN
   input  logic [3*CW-1:0]            border_rgb,
`endif
   output logic                       pending,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       de,
   output logic                       frame_start,
   output logic [CW-1:0]              red,
   output logic [CW-1:0]              green,
   output logic [CW-1:0]              blue
);

   localparam int   NT   = COLS * ROWS;
   localparam int   W    = NT * 3 * CW;
   localparam int   CIW  = idx_w(COLS);
   localparam int   RIW  = idx_w(ROWS);
   localparam int   KW   = idx_w(NT);
   localparam logic HPOL = (H_SYNC_POL != 0);
   localparam logic VPOL = (V_SYNC_POL != 0);

   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } pix_t;

   logic           visible, hsync_act, vsync_act, frame_first, frame_end;
   logic [CIW-1:0] col;
   logic [RIW-1:0] row;
`ifdef VGA_BORDER_EN
   logic           tile_edge;
`endif

   vga_timing #(
      .H_VISIBLE (H_VISIBLE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_VISIBLE (V_VISIBLE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .COLS      (COLS),      .ROWS (ROWS)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .visible     (visible),
      .hsync_act   (hsync_act),
      .vsync_act   (vsync_act),
      .frame_first (frame_first),
      .col         (col),
      .row         (row),
`ifdef VGA_BORDER_EN
      .tile_edge   (tile_edge),
`endif
      .frame_end   (frame_end)
   );

   logic [W-1:0]  shadow_q, shadow_d;
   logic [W-1:0]  active_q, active_d;
   logic          pending_q, pending_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic          frame_start_q, frame_start_d;
   pix_t          pix_q, pix_d;
   pix_t          tile_pix;
   logic [KW-1:0] tile_idx;
   logic          swap;

   always_comb begin
      // Active takes the old shadow at frame end even if a load lands on the
      // same cycle; that load then leaves pending set for the next frame.
      swap      = frame_end && pending_q;
      shadow_d  = code_load ? code : shadow_q;
      active_d  = swap ? shadow_q : active_q;
      pending_d = code_load ? 1'b1 : (swap ? 1'b0 : pending_q);

      tile_idx  = KW'(KW'(row) * KW'(COLS) + KW'(col));
      tile_pix  = '0;
      for (int k = 0; k < NT; k++) begin
         if (tile_idx == KW'(k)) tile_pix = active_q[W-1-3*CW*k -: 3*CW];
      end

      pix_d = '0;
      if (visible) begin
`ifdef VGA_BORDER_EN
         pix_d = tile_edge ? pix_t'(border_rgb) : tile_pix;
`else
         pix_d = tile_pix;
`endif
      end

      hsync_d       = hsync_act ? HPOL : ~HPOL;
      vsync_d       = vsync_act ? VPOL : ~VPOL;
      de_d          = visible;
      frame_start_d = frame_first;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: shadow and active are ordinary flops, so they take the reset
         // too; that is what makes the first frame after reset show colour 0.
         shadow_q      <= '0;
         active_q      <= '0;
         pending_q     <= 1'b0;
         hsync_q       <= ~HPOL;
         vsync_q       <= ~VPOL;
         de_q          <= 1'b0;
         frame_start_q <= 1'b0;
         pix_q         <= '0;
      end else begin
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         frame_start_q <= frame_start_d;
         pix_q         <= pix_d;
      end
   end

   assign pending     = pending_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign frame_start = frame_start_q;
   assign red         = pix_q.r;
   assign green       = pix_q.g;
   assign blue        = pix_q.b;

endmodule

// File: tb/tb_vga_tile_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_tile_gen
// Small-timing bench for vga_tile_gen (H 8/2/2/2, V 4/1/1/1, 2x2 tiles).
// A behavioural raster model predicts each cycle's registered outputs when the
// inputs are driven; the prediction is queued and compared on the next
// negative edge. Directed checks cover reset, loads, frame-end loads, sync
// counts and the frame_start spacing after a mid-frame reset.
// With VGA_BORDER_EN the visible height becomes 6 so tiles have an interior.
// -----------------------------------------------------------------------------
module tb_vga_tile_gen;

   localparam int HV = 8, HF = 2, HS = 2, HB = 2;
`ifdef VGA_BORDER_EN
   localparam int VV = 6;
`else
   localparam int VV = 4;
`endif
   localparam int VF = 1, VS = 1, VB = 1;
   localparam int COLS = 2, ROWS = 2, CW = 4;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int W  = COLS * ROWS * 3 * CW;
   localparam int TW = HV / COLS;
   localparam int TH = VV / ROWS;
   localparam logic HPOL = 1'b1, VPOL = 1'b1;
   localparam logic H_IDLE = ~HPOL, V_IDLE = ~VPOL;
   localparam logic [11:0] BORDER = 12'h888;
`ifdef VGA_BORDER_EN
   localparam int R0V = 1, R1V = 4;
`else
   localparam int R0V = 0, R1V = 2;
`endif

   localparam logic [W-1:0] CODE_A = {12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
   localparam logic [W-1:0] CODE_B = {12'h123, 12'h456, 12'h789, 12'hABC};
   localparam logic [W-1:0] CODE_C = {12'h5A5, 12'h3C3, 12'h0E1, 12'h777};

   typedef struct packed {
      logic          pending;
      logic          hsync;
      logic          vsync;
      logic          de;
      logic          fs;
      logic [3*CW-1:0] rgb;
   } out_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  code;
   logic          code_load;
   logic [3*CW-1:0] border_rgb;
   logic          pending, hsync, vsync, de, frame_start;
   logic [CW-1:0] red, green, blue;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state (value before the next active edge)
   int           mh, mv;
   logic [W-1:0] m_shadow, m_active;
   logic         m_pending;
   out_t         exp_q[$];

   logic stat_en = 1'b0;
   int   hs_n = 0, vs_n = 0, de_n = 0, fs_n = 0;

   always #5 clk = ~clk;

   vga_tile_gen #(
      .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .H_SYNC_POL (1), .V_SYNC_POL (1),
      .COLS (COLS), .ROWS (ROWS), .CW (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .code        (code),
      .code_load   (code_load),
`ifdef VGA_BORDER_EN
      .border_rgb  (border_rgb),
`endif
      .pending     (pending),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .frame_start (frame_start),
      .red         (red),
      .green       (green),
      .blue        (blue)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic out_t model_out(input logic r);
      out_t o;
      int   k;
      o = '0;
      if (r) begin
         o.hsync = H_IDLE;
         o.vsync = V_IDLE;
      end else begin
         o.hsync = (mh >= HV + HF && mh < HV + HF + HS) ? HPOL : H_IDLE;
         o.vsync = (mv >= VV + VF && mv < VV + VF + VS) ? VPOL : V_IDLE;
         o.de    = (mh < HV) && (mv < VV);
         o.fs    = (mh == 0) && (mv == 0);
         if (o.de) begin
            k     = (mv / TH) * COLS + (mh / TW);
            o.rgb = m_active[W-1-3*CW*k -: 3*CW];
`ifdef VGA_BORDER_EN
            if ((mh % TW == 0) || (mh % TW == TW - 1) || (mv % TH == 0) || (mv % TH == TH - 1))
               o.rgb = BORDER;
`endif
         end
      end
      return o;
   endfunction

   task automatic model_advance(input logic r, input logic ld, input logic [W-1:0] c);
      logic fe;
      if (r) begin
         mh = 0; mv = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0;
      end else begin
         fe = (mh == HT - 1) && (mv == VT - 1);
         if (fe && m_pending) m_active = m_shadow;
         if (ld) begin
            m_shadow  = c;
            m_pending = 1'b1;
         end else if (fe && m_pending) begin
            m_pending = 1'b0;
         end
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end
   endtask

   // One clock: compare last cycle's outputs, drive new inputs, queue prediction.
   task automatic step(input logic r, input logic ld, input logic [W-1:0] c);
      out_t got, e;
      @(negedge clk);
      got = {pending, hsync, vsync, de, frame_start, red, green, blue};
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("sb_cyc%0d", cyc), 32'(got), 32'(e));
      end
      if (stat_en) begin
         hs_n += (got.hsync == HPOL) ? 1 : 0;
         vs_n += (got.vsync == VPOL) ? 1 : 0;
         de_n += got.de ? 1 : 0;
         fs_n += got.fs ? 1 : 0;
      end
      rst       = r;
      code_load = ld;
      code      = c;
      e         = model_out(r);
      model_advance(r, ld, c);
      e.pending = m_pending;
      exp_q.push_back(e);
      cyc++;
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int h, input int v);
      int n;
      n = 0;
      while (!(mh == h && mv == v) && n <= FT) begin
         step(1'b0, 1'b0, '0);
         n++;
      end
      if (!(mh == h && mv == v)) check("run_to", 32'(mh * 1000 + mv), 32'(h * 1000 + v));
   endtask

   task automatic pixel_check(input string tag, input int h, input int v, input logic [11:0] exp);
      run_to(h, v);
      step(1'b0, 1'b0, '0);
      sample();
      check(tag, {20'd0, red, green, blue}, {20'd0, exp});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst        = 1'b1;
      code_load  = 1'b0;
      code       = '0;
      border_rgb = BORDER;
      mh = 0; mv = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0;

      // reset state
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
      sample();
      check("rst_hsync", 32'(hsync), 32'(H_IDLE));
      check("rst_vsync", 32'(vsync), 32'(V_IDLE));
      check("rst_de", 32'(de), 0);
      check("rst_fs", 32'(frame_start), 0);
      check("rst_pend", 32'(pending), 0);
      check("rst_rgb", {20'd0, red, green, blue}, 0);

      // two frames; sync/enable counts over one full frame period
      for (int i = 0; i < FT; i++) step(1'b0, 1'b0, '0);
      stat_en = 1'b1;
      for (int i = 0; i < FT; i++) step(1'b0, 1'b0, '0);
      stat_en = 1'b0;
      check("hs_per_frame", 32'(hs_n), 32'(HS * VT));
      check("vs_per_frame", 32'(vs_n), 32'(VS * HT));
      check("de_per_frame", 32'(de_n), 32'(HV * VV));
      check("fs_per_frame", 32'(fs_n), 1);

      // mid-frame load: pending now, visible next frame
      run_to(3, 1);
      step(1'b0, 1'b1, CODE_A);
      sample();
      check("load_pend", 32'(pending), 1);
      run_to(HT - 1, VT - 1);
      step(1'b0, 1'b0, '0);
      sample();
      check("swap_pend", 32'(pending), 0);
`ifdef VGA_BORDER_EN
      pixel_check("border_px", 0, 0, BORDER);
`endif
      pixel_check("tile0", 1, R0V, 12'hF00);
      pixel_check("tile1", 5, R0V, 12'h0F0);
      pixel_check("tile2", 1, R1V, 12'h00F);
      pixel_check("tile3", 5, R1V, 12'hFFF);

      // load on the frame-end cycle while a code is already pending
      run_to(2, VV);
      step(1'b0, 1'b1, CODE_B);
      run_to(HT - 1, VT - 1);
      step(1'b0, 1'b1, CODE_C);
      sample();
      check("fe_load_pend", 32'(pending), 1);
      pixel_check("fe_old_shadow", 1, R0V, 12'h123);
      run_to(HT - 1, VT - 1);
      step(1'b0, 1'b0, '0);
      pixel_check("fe_new_code", 5, R1V, 12'h777);
      check("fe_pend_clear", 32'(pending), 0);

      // mid-frame reset at h=5, v=2 with a load outstanding
      run_to(4, 2);
      step(1'b0, 1'b1, CODE_A);
      step(1'b1, 1'b0, '0);
      sample();
      check("mrst_hsync", 32'(hsync), 32'(H_IDLE));
      check("mrst_vsync", 32'(vsync), 32'(V_IDLE));
      check("mrst_de", 32'(de), 0);
      check("mrst_pend", 32'(pending), 0);
      check("mrst_rgb", {20'd0, red, green, blue}, 0);
      n = 0;
      do begin
         step(1'b0, 1'b0, '0);
         n++;
         sample();
      end while (!frame_start && n < 2 * FT);
      check("fs_after_rst", 32'(n), 1);
      do begin
         step(1'b0, 1'b0, '0);
         n++;
         sample();
      end while (!frame_start && n < 3 * FT);
      check("fs_next", 32'(n), 32'(FT + 1));

      step(1'b0, 1'b0, '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
